raster_to_macroblock: RTL and testbench
=======================================

Name: raster_to_macroblock

Overview:
Upstream feeder for the macroblock image-transfer stage. Accepts a raster-ordered RGB24 pixel stream from the sensor/capture path and buffers MB_SIZE lines (one stripe) in a double-banked stripe RAM. It then re-emits each stripe as consecutive MB_SIZE×MB_SIZE macroblocks on a tIImageTransfer.src port. The interface has no backpressure, so the block guarantees emission at one pixel per clock.

Parameters:
IMAGE_WIDTH, 640, active pixels per line; must be a multiple of MB_SIZE.
MB_SIZE, 8, macroblock edge in pixels; must be a power of two ≥2.

Ports:
ul1Clock  input  1  common clock; also clocks the tIImageTransfer instance.
ul1Reset_n  input  1  reset, asynchronous, active-low.
ul1PixelValid  input  1  ul24PixelData valid this cycle.
ul24PixelData  input  24  raster RGB24 pixel.
ul1FrameStart  input  1  qualifies the first pixel of a frame; valid only with ul1PixelValid.
ul1LineEnd  input  1  qualifies the last pixel of a line; valid only with ul1PixelValid.
iImageOut  tIImageTransfer.src  —  macroblock output: ul1Active, eMacroBlockType, ul24Rgb24Data, ul1MacroBlockEnd.

Behaviour:
- Reset (async assert, sync-safe release): ul1Active=0, ul24Rgb24Data=0, ul1MacroBlockEnd=0, eMacroBlockType=MB_RGB24. All counters 0, write bank 0, reader IDLE, both banks empty.
- eMacroBlockType is constant MB_RGB24.
- Writer, per accepted pixel:
  - Address = wbank·MB_SIZE·IMAGE_WIDTH + wline·IMAGE_WIDTH + wcol.
  - Pixels with wcol ≥ IMAGE_WIDTH are dropped.
  - ul1LineEnd: wcol←0, wline++. A short line leaves its missing RAM words stale.
  - ul1FrameStart: the pixel is written at wcol=0, wline=0. Any partial stripe in the write bank is discarded; the reader is not affected.
  - Stripe complete when the line with wline=MB_SIZE−1 ends. Then mark wbank full, toggle wbank, wline←0.
- Reader FSM:
  - IDLE→EMIT on the cycle after any bank becomes full; that bank becomes rbank.
  - EMIT loop order: mb 0..IMAGE_WIDTH/MB_SIZE−1, then row 0..MB_SIZE−1, then col 0..MB_SIZE−1.
  - Read address = rbank·MB_SIZE·IMAGE_WIDTH + row·IMAGE_WIDTH + mb·MB_SIZE + col.
  - RAM read latency 1; ul1Active/ul1MacroBlockEnd are pipelined to align with the data.
  - Last address of the stripe issued: mark rbank empty. If the other bank is full, continue seamlessly (no idle cycle); else go to IDLE.
- Latency: last pixel of stripe accepted in cycle N → first macroblock pixel has ul1Active=1 in cycle N+2.
- Output per stripe: exactly MB_SIZE·IMAGE_WIDTH contiguous active cycles. ul1MacroBlockEnd=1 exactly on each macroblock's pixel (MB_SIZE−1, MB_SIZE−1). ul24Rgb24Data=0 whenever ul1Active=0.
- Writing into a bank the reader still owns (overrun): the writer still writes. Handling is defined under Optional Feature.
- Simultaneous stripe completion and reader finish: the swap is seen the same cycle and emission stays contiguous.

Optional Feature:
- Macro: RASTER_TO_MB_OVERRUN_EN.
- Defined:
  - Extra output port ul1Overrun (1 bit).
  - Set when a pixel is accepted while wbank is still full/being read.
  - Sticky; cleared by reset or an accepted ul1FrameStart pixel.
  - The offending stripe is not marked full, so it is never emitted.
- Undefined: no port, no detection. Writes land regardless and the stripe is emitted, possibly corrupt.

Decomposition:
- P_ImageProcessing: teMacroBlockType including MB_RGB24; function fMbAddrWidth(width, mb) = $clog2(2·mb·width).
- Sub-module tp_stripe_ram: simple dual-port, 1 write/1 read per clock, registered read, depth 2·MB_SIZE·IMAGE_WIDTH × 24 bits, no reset on the array.

Test Plan (IMAGE_WIDTH=16, MB_SIZE=4; pixel = {line[7:0], col[7:0], 8'h00}):
- One frame, 4 lines continuous → 64 active cycles; first active cycle N+2. Data order 0x000000, 0x000100, 0x000200, 0x000300, 0x010000…; ul1MacroBlockEnd on 0x030300, 0x030700, 0x030B00, 0x030F00.
- 8 lines back-to-back, no blanking → 128 contiguous active cycles, no gap. The second stripe starts with 0x040000.
- ul1FrameStart asserted at line 2 of stripe → partial stripe discarded; next emission starts with the new frame's line 0.
- Reset asserted mid-EMIT → ul1Active=0 and ul1MacroBlockEnd=0 in the same cycle (async). After release, no output until a full new stripe.
- Over-long line (20 pixels before ul1LineEnd) → pixels 16–19 dropped; emitted data is identical to the 16-pixel case.
- With RASTER_TO_MB_OVERRUN_EN, force RAM-full scenario (third stripe before reader drains, reader stalled via force) → ul1Overrun=1 and the stripe is not emitted. ul1Overrun clears on the next ul1FrameStart.

Source files
------------

// File: rtl/P_ImageProcessing.sv
// Shared image-processing types: macroblock type enumeration, the reader
// state encoding and the stripe-RAM address width helper.
package P_ImageProcessing;

    typedef enum logic [1:0] {
        MB_RGB24  = 2'd0,
        MB_YUV444 = 2'd1,
        MB_YUV420 = 2'd2,
        MB_RAW8   = 2'd3
    } teMacroBlockType;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_EMIT = 1'b1
    } teReaderState;

    // Address width of a two-bank stripe RAM holding mb lines of width pixels.
    function automatic int fMbAddrWidth(input int width, input int mb);
        return $clog2(2 * mb * width);
    endfunction

endpackage

// File: rtl/tIImageTransfer.sv
// Macroblock image-transfer link. The source drives one pixel per clock with
// no backpressure; ul1MacroBlockEnd marks the last pixel of each macroblock.
interface tIImageTransfer (input logic ul1Clock);
    import P_ImageProcessing::*;

    logic            ul1Active;
    teMacroBlockType eMacroBlockType;
    logic [23:0]     ul24Rgb24Data;
    logic            ul1MacroBlockEnd;

    modport src (input ul1Clock, output ul1Active, output eMacroBlockType,
                 output ul24Rgb24Data, output ul1MacroBlockEnd);
    modport dst (input ul1Clock, input ul1Active, input eMacroBlockType,
                 input ul24Rgb24Data, input ul1MacroBlockEnd);
endinterface

// File: rtl/tp_stripe_ram.sv
// Simple dual-port stripe RAM: one write and one registered read per clock.
// The array itself is not reset; the read register returns to zero on any
// cycle without a read so an idle output carries no stale pixel.
module tp_stripe_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_r [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, zero when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_r[raddr];
        end else begin
            rdata <= '0;
        end
    end
endmodule

// File: rtl/raster_to_macroblock.sv
// Raster-to-macroblock converter. Buffers MB_SIZE raster lines per stripe in a
// two-bank RAM and re-emits every full stripe as MB_SIZE x MB_SIZE macroblocks
// at one pixel per clock. Optional macro RASTER_TO_MB_OVERRUN_EN adds the
// ul1Overrun flag and drops stripes written into a bank still being read.
module raster_to_macroblock
    import P_ImageProcessing::*;
#(
    parameter int IMAGE_WIDTH = 640,
    parameter int MB_SIZE     = 8
) (
    input  logic        ul1Clock,
    input  logic        ul1Reset_n,
    input  logic        ul1PixelValid,
    input  logic [23:0] ul24PixelData,
    input  logic        ul1FrameStart,
    input  logic        ul1LineEnd,
`ifdef RASTER_TO_MB_OVERRUN_EN
    output logic        ul1Overrun,
`endif
    tIImageTransfer.src iImageOut
);
    localparam int AW    = fMbAddrWidth(IMAGE_WIDTH, MB_SIZE);
    localparam int DEPTH = 2 * MB_SIZE * IMAGE_WIDTH;
    localparam int NMB   = IMAGE_WIDTH / MB_SIZE;
    localparam int LW    = $clog2(MB_SIZE);
    localparam int CW    = $clog2(IMAGE_WIDTH + 1);
    localparam int MBW   = (NMB > 1) ? $clog2(NMB) : 1;

    localparam logic [AW-1:0]  STRIPE_WORDS = AW'(MB_SIZE * IMAGE_WIDTH);
    localparam logic [AW-1:0]  LINE_WORDS   = AW'(IMAGE_WIDTH);
    localparam logic [AW-1:0]  MB_WORDS     = AW'(MB_SIZE);
    localparam logic [LW-1:0]  LAST_IDX     = LW'(MB_SIZE - 1);
    localparam logic [MBW-1:0] LAST_MB      = MBW'(NMB - 1);
    localparam logic [CW-1:0]  WIDTH_C      = CW'(IMAGE_WIDTH);

    // Writer state
    logic          wbank_r;
    logic [LW-1:0] wline_r;
    logic [CW-1:0] wcol_r;
    logic [CW-1:0] col_eff_s;
    logic [LW-1:0] line_eff_s;
    logic          we_s;
    logic [AW-1:0] waddr_s;
    logic          stripe_done_s;
    logic          set_full_s;

    // Reader state
    teReaderState   state_r;
    logic           rbank_r;
    logic [MBW-1:0] mb_r;
    logic [LW-1:0]  row_r;
    logic [LW-1:0]  col_r;
    logic [1:0]     full_r;
    logic           active_r;
    logic           mbend_r;

    logic           start_s;
    logic           issue_s;
    logic           cur_bank_s;
    logic           mbend_s;
    logic           last_s;
    logic           other_full_s;
    logic [AW-1:0]  raddr_s;
    logic [MBW-1:0] mb_n_s;
    logic [LW-1:0]  row_n_s;
    logic [LW-1:0]  col_n_s;
    logic [1:0]     full_n_s;
    logic [23:0]    rdata_s;

    // Write position for the current pixel; a frame start restarts the stripe.
    always_comb begin
        col_eff_s  = wcol_r;
        line_eff_s = wline_r;
        if (ul1FrameStart) begin
            col_eff_s  = '0;
            line_eff_s = '0;
        end else begin
            col_eff_s  = wcol_r;
            line_eff_s = wline_r;
        end
        we_s          = ul1PixelValid && (col_eff_s < WIDTH_C);
        waddr_s       = (wbank_r ? STRIPE_WORDS : '0) + AW'(line_eff_s) * LINE_WORDS + AW'(col_eff_s);
        stripe_done_s = ul1PixelValid && ul1LineEnd && (line_eff_s == LAST_IDX);
    end

`ifdef RASTER_TO_MB_OVERRUN_EN
    logic bad_r;
    logic overrun_r;
    logic busy_s;

    assign busy_s     = full_r[wbank_r];
    assign set_full_s = stripe_done_s && !bad_r && !busy_s;
    assign ul1Overrun = overrun_r;

    // Sticky overrun flag and per-stripe corruption marker.
    always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
        if (!ul1Reset_n) begin
            overrun_r <= 1'b0;
            bad_r     <= 1'b0;
        end else if (ul1PixelValid) begin
            if (ul1FrameStart) begin
                overrun_r <= busy_s;
            end else begin
                overrun_r <= overrun_r | busy_s;
            end
            if (stripe_done_s) begin
                bad_r <= 1'b0;
            end else if (ul1FrameStart) begin
                bad_r <= busy_s;
            end else begin
                bad_r <= bad_r | busy_s;
            end
        end else begin
            overrun_r <= overrun_r;
            bad_r     <= bad_r;
        end
    end
`else
    assign set_full_s = stripe_done_s;
`endif

    // Writer column/line/bank tracking; over-long lines saturate the column.
    always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
        if (!ul1Reset_n) begin
            wbank_r <= 1'b0;
            wline_r <= '0;
            wcol_r  <= '0;
        end else if (ul1PixelValid) begin
            if (ul1LineEnd) begin
                wcol_r <= '0;
                if (stripe_done_s) begin
                    wline_r <= '0;
                end else begin
                    wline_r <= line_eff_s + LW'(1'b1);
                end
            end else begin
                wline_r <= line_eff_s;
                if (col_eff_s < WIDTH_C) begin
                    wcol_r <= col_eff_s + CW'(1'b1);
                end else begin
                    wcol_r <= col_eff_s;
                end
            end
            if (set_full_s) begin
                wbank_r <= ~wbank_r;
            end else begin
                wbank_r <= wbank_r;
            end
        end else begin
            wbank_r <= wbank_r;
            wline_r <= wline_r;
            wcol_r  <= wcol_r;
        end
    end

    // Reader address, macroblock counters and bank hand-over decisions.
    always_comb begin
        start_s = (state_r == RD_IDLE) && (full_r != 2'b00);
        issue_s = start_s || (state_r == RD_EMIT);
        if (start_s) begin
            if (full_r[~wbank_r]) begin
                cur_bank_s = ~wbank_r;
            end else begin
                cur_bank_s = wbank_r;
            end
        end else begin
            cur_bank_s = rbank_r;
        end
        raddr_s = (cur_bank_s ? STRIPE_WORDS : '0) + AW'(row_r) * LINE_WORDS
                + AW'(mb_r) * MB_WORDS + AW'(col_r);
        mbend_s = issue_s && (row_r == LAST_IDX) && (col_r == LAST_IDX);
        last_s  = mbend_s && (mb_r == LAST_MB);
        // A stripe completing this very cycle counts, so emission stays contiguous.
        other_full_s = full_r[~cur_bank_s] || (set_full_s && (wbank_r == ~cur_bank_s));

        col_n_s = col_r + LW'(1'b1);
        row_n_s = row_r;
        mb_n_s  = mb_r;
        if (col_r == LAST_IDX) begin
            row_n_s = row_r + LW'(1'b1);
            if (row_r == LAST_IDX) begin
                mb_n_s = mb_r + MBW'(1'b1);
            end else begin
                mb_n_s = mb_r;
            end
        end else begin
            row_n_s = row_r;
        end

        full_n_s = full_r;
        if (last_s) begin
            full_n_s[cur_bank_s] = 1'b0;
        end else begin
            full_n_s[cur_bank_s] = full_r[cur_bank_s];
        end
        if (set_full_s) begin
            full_n_s[wbank_r] = 1'b1;
        end else begin
            full_n_s[wbank_r] = full_n_s[wbank_r];
        end
    end

    // Reader FSM with bank-full flags and output pipeline aligned to RAM latency.
    always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
        if (!ul1Reset_n) begin
            state_r  <= RD_IDLE;
            rbank_r  <= 1'b0;
            mb_r     <= '0;
            row_r    <= '0;
            col_r    <= '0;
            full_r   <= 2'b00;
            active_r <= 1'b0;
            mbend_r  <= 1'b0;
        end else begin
            active_r <= issue_s;
            mbend_r  <= mbend_s;
            full_r   <= full_n_s;
            case (state_r)
                RD_IDLE: begin
                    if (start_s) begin
                        state_r <= RD_EMIT;
                        rbank_r <= cur_bank_s;
                        mb_r    <= mb_n_s;
                        row_r   <= row_n_s;
                        col_r   <= col_n_s;
                    end else begin
                        state_r <= RD_IDLE;
                    end
                end
                RD_EMIT: begin
                    if (last_s) begin
                        mb_r  <= '0;
                        row_r <= '0;
                        col_r <= '0;
                        if (other_full_s) begin
                            state_r <= RD_EMIT;
                            rbank_r <= ~cur_bank_s;
                        end else begin
                            state_r <= RD_IDLE;
                        end
                    end else begin
                        mb_r  <= mb_n_s;
                        row_r <= row_n_s;
                        col_r <= col_n_s;
                    end
                end
                default: begin
                    state_r <= RD_IDLE;
                    mb_r    <= '0;
                    row_r   <= '0;
                    col_r   <= '0;
                end
            endcase
        end
    end

    tp_stripe_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (24)
    ) u_ram (
        .clk   (ul1Clock),
        .rst_n (ul1Reset_n),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (ul24PixelData),
        .re    (issue_s),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    assign iImageOut.ul1Active        = active_r;
    assign iImageOut.ul1MacroBlockEnd = mbend_r;
    assign iImageOut.ul24Rgb24Data    = rdata_s;
    assign iImageOut.eMacroBlockType  = MB_RGB24;
endmodule

// File: tb/tb_raster_to_macroblock.sv
// Directed bench for raster_to_macroblock at IMAGE_WIDTH=16, MB_SIZE=4.
// Pixels are tagged {line[7:0], col[7:0], 8'h00}.
module tb_raster_to_macroblock;
    import P_ImageProcessing::*;

    localparam int W  = 16;
    localparam int MB = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        pv    = 1'b0;
    logic        fs    = 1'b0;
    logic        le    = 1'b0;
    logic [23:0] pd    = 24'h0;
`ifdef RASTER_TO_MB_OVERRUN_EN
    logic        ovr;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int idle_dirty = 0;

    logic [23:0] q_data[$];
    logic        q_end[$];
    int          q_cyc[$];

    tIImageTransfer img (.ul1Clock(clk));

    raster_to_macroblock #(.IMAGE_WIDTH(W), .MB_SIZE(MB)) dut (
        .ul1Clock      (clk),
        .ul1Reset_n    (rst_n),
        .ul1PixelValid (pv),
        .ul24PixelData (pd),
        .ul1FrameStart (fs),
        .ul1LineEnd    (le),
`ifdef RASTER_TO_MB_OVERRUN_EN
        .ul1Overrun    (ovr),
`endif
        .iImageOut     (img)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture active output pixels; count idle cycles carrying data or end flags.
    always @(negedge clk) begin
        if (img.ul1Active === 1'b1) begin
            q_data.push_back(img.ul24Rgb24Data);
            q_end.push_back(img.ul1MacroBlockEnd);
            q_cyc.push_back(cyc);
        end else if (img.ul24Rgb24Data !== 24'h0 || img.ul1MacroBlockEnd !== 1'b0) begin
            idle_dirty <= idle_dirty + 1;
        end
    end

    function automatic logic [23:0] exp_px(input int base, input int i);
        int mb  = i / 16;
        int row = (i / 4) % 4;
        int col = i % 4;
        int ln  = base + row;
        int cc  = mb * 4 + col;
        return {ln[7:0], cc[7:0], 8'h00};
    endfunction

    function automatic logic exp_end(input int i);
        return ((i % 16) == 15);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_end.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        pv = 1'b0; fs = 1'b0; le = 1'b0; pd = 24'h0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_q();
    endtask

    task automatic send_line(input int tag, input int npix, input logic first, output int last_c);
        last_c = 0;
        for (int c = 0; c < npix; c++) begin
            pv = 1'b1;
            pd = {tag[7:0], c[7:0], 8'h00};
            fs = first && (c == 0);
            le = (c == npix - 1);
            last_c = cyc;
            tick();
        end
        pv = 1'b0; fs = 1'b0; le = 1'b0; pd = 24'h0;
    endtask

    task automatic send_stripe(input int base, input int npix, input logic first, output int last_c);
        for (int l = 0; l < MB; l++) begin
            send_line(base + l, npix, first && (l == 0), last_c);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (img.ul1Active !== 1'b0) begin
            errors++; $display("FAIL reset_active got %b want 0", img.ul1Active);
        end
        checks++;
        if (img.ul1MacroBlockEnd !== 1'b0) begin
            errors++; $display("FAIL reset_mbend got %b want 0", img.ul1MacroBlockEnd);
        end
        do_reset();
        checks++;
        if (img.ul24Rgb24Data !== 24'h0) begin
            errors++; $display("FAIL reset_data got %h want 000000", img.ul24Rgb24Data);
        end
        checks++;
        if (img.eMacroBlockType !== MB_RGB24) begin
            errors++; $display("FAIL reset_type got %0d want %0d", img.eMacroBlockType, MB_RGB24);
        end
    endtask

    task automatic test_single_stripe();
        int last_c;
        int dirty0;
        do_reset();
        dirty0 = idle_dirty;
        send_stripe(0, 16, 1'b1, last_c);
        repeat (90) tick();
        checks++;
        if (q_data.size() != 64) begin
            errors++; $display("FAIL single_count got %0d want 64", q_data.size());
        end else begin
            checks++;
            if (q_cyc[0] != last_c + 2) begin
                errors++; $display("FAIL single_latency got cycle %0d want %0d", q_cyc[0], last_c + 2);
            end
            checks++;
            if (q_cyc[63] - q_cyc[0] != 63) begin
                errors++; $display("FAIL single_contig got span %0d want 63", q_cyc[63] - q_cyc[0]);
            end
            checks++;
            if (q_data[1] !== 24'h000100 || q_data[3] !== 24'h000300 || q_data[4] !== 24'h010000) begin
                errors++; $display("FAIL single_order got %h %h %h want 000100 000300 010000", q_data[1], q_data[3], q_data[4]);
            end
            checks++;
            if (q_data[15] !== 24'h030300 || q_data[31] !== 24'h030700 || q_data[47] !== 24'h030b00 || q_data[63] !== 24'h030f00) begin
                errors++; $display("FAIL single_mbend_data got %h %h %h %h", q_data[15], q_data[31], q_data[47], q_data[63]);
            end
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (q_data[i] !== exp_px(0, i) || q_end[i] !== exp_end(i)) begin
                    errors++; $display("FAIL single_px[%0d] got %h/%b want %h/%b", i, q_data[i], q_end[i], exp_px(0, i), exp_end(i));
                end
            end
        end
        checks++;
        if (idle_dirty != dirty0) begin
            errors++; $display("FAIL single_idle_clean got %0d dirty idle cycles want 0", idle_dirty - dirty0);
        end
    endtask

    task automatic test_back_to_back();
        int last_c;
        do_reset();
        send_stripe(0, 16, 1'b1, last_c);
        send_stripe(4, 16, 1'b0, last_c);
        repeat (90) tick();
        checks++;
        if (q_data.size() != 128) begin
            errors++; $display("FAIL b2b_count got %0d want 128", q_data.size());
        end else begin
            checks++;
            if (q_cyc[127] - q_cyc[0] != 127) begin
                errors++; $display("FAIL b2b_contig got span %0d want 127", q_cyc[127] - q_cyc[0]);
            end
            checks++;
            if (q_data[64] !== 24'h040000) begin
                errors++; $display("FAIL b2b_second_start got %h want 040000", q_data[64]);
            end
            for (int i = 0; i < 128; i++) begin
                checks++;
                if (q_data[i] !== exp_px((i < 64) ? 0 : 4, i % 64) || q_end[i] !== exp_end(i % 64)) begin
                    errors++; $display("FAIL b2b_px[%0d] got %h/%b want %h", i, q_data[i], q_end[i], exp_px((i < 64) ? 0 : 4, i % 64));
                end
            end
        end
    endtask

    task automatic test_frame_restart();
        int last_c;
        do_reset();
        send_line(8'h50, 16, 1'b1, last_c);
        send_line(8'h51, 16, 1'b0, last_c);
        send_stripe(0, 16, 1'b1, last_c);
        repeat (90) tick();
        checks++;
        if (q_data.size() != 64) begin
            errors++; $display("FAIL restart_count got %0d want 64", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 24'h000000 || q_data[4] !== 24'h010000) begin
                errors++; $display("FAIL restart_first got %h %h want 000000 010000", q_data[0], q_data[4]);
            end
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (q_data[i] !== exp_px(0, i)) begin
                    errors++; $display("FAIL restart_px[%0d] got %h want %h", i, q_data[i], exp_px(0, i));
                end
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        int  last_c;
        bit  seen;
        do_reset();
        send_stripe(0, 16, 1'b1, last_c);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (img.ul1MacroBlockEnd === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL midrst_wait got no mbend within 40 cycles want one");
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (img.ul1Active !== 1'b0 || img.ul1MacroBlockEnd !== 1'b0 || img.ul24Rgb24Data !== 24'h0) begin
            errors++; $display("FAIL midrst_async got act=%b end=%b data=%h want 0 0 000000",
                               img.ul1Active, img.ul1MacroBlockEnd, img.ul24Rgb24Data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        clear_q();
        repeat (100) tick();
        checks++;
        if (q_data.size() != 0) begin
            errors++; $display("FAIL midrst_quiet got %0d active cycles want 0", q_data.size());
        end
        send_stripe(8, 16, 1'b1, last_c);
        repeat (90) tick();
        checks++;
        if (q_data.size() != 64) begin
            errors++; $display("FAIL midrst_new_count got %0d want 64", q_data.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (q_data[i] !== exp_px(8, i)) begin
                    errors++; $display("FAIL midrst_px[%0d] got %h want %h", i, q_data[i], exp_px(8, i));
                end
            end
        end
    endtask

    task automatic test_long_line();
        int last_c;
        do_reset();
        send_stripe(0, 20, 1'b1, last_c);
        repeat (90) tick();
        checks++;
        if (q_data.size() != 64) begin
            errors++; $display("FAIL long_count got %0d want 64", q_data.size());
        end else begin
            checks++;
            if (q_cyc[0] != last_c + 2) begin
                errors++; $display("FAIL long_latency got cycle %0d want %0d", q_cyc[0], last_c + 2);
            end
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (q_data[i] !== exp_px(0, i)) begin
                    errors++; $display("FAIL long_px[%0d] got %h want %h", i, q_data[i], exp_px(0, i));
                end
            end
        end
    endtask

`ifdef RASTER_TO_MB_OVERRUN_EN
    task automatic test_overrun();
        int last_c;
        int n;
        do_reset();
        send_stripe(0, 16, 1'b1, last_c);
        force dut.mb_r = '0;
        send_stripe(4, 16, 1'b0, last_c);
        checks++;
        if (ovr !== 1'b0) begin
            errors++; $display("FAIL ovr_early got %b want 0", ovr);
        end
        send_stripe(8, 16, 1'b0, last_c);
        checks++;
        if (ovr !== 1'b1) begin
            errors++; $display("FAIL ovr_set got %b want 1", ovr);
        end
        clear_q();
        release dut.mb_r;
        repeat (300) tick();
        n = q_data.size();
        checks++;
        if (n < 64 || n > 128) begin
            errors++; $display("FAIL ovr_drain_count got %0d want 64..128", n);
        end else begin
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (q_data[n - 64 + i] !== exp_px(4, i)) begin
                    errors++; $display("FAIL ovr_tail_px[%0d] got %h want %h", i, q_data[n - 64 + i], exp_px(4, i));
                end
            end
        end
        checks++;
        if (ovr !== 1'b1) begin
            errors++; $display("FAIL ovr_sticky got %b want 1", ovr);
        end
        send_line(0, 16, 1'b1, last_c);
        checks++;
        if (ovr !== 1'b0) begin
            errors++; $display("FAIL ovr_clear got %b want 0", ovr);
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_stripe();
        test_back_to_back();
        test_frame_restart();
        test_reset_mid_emit();
        test_long_line();
`ifdef RASTER_TO_MB_OVERRUN_EN
        test_overrun();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
